// File: rtl/alu_writeback_seq_pkg.sv
// Shared datapath definitions: widths, writeback FSM states, flag indices.
// Used by the logic unit, branch unit and writeback sequencer.
package alu_writeback_seq_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;
    localparam int FLAG_W = 5;

    localparam int FLAG_ZA = 4;
    localparam int FLAG_ZB = 3;
    localparam int FLAG_EQ = 2;
    localparam int FLAG_GT = 1;
    localparam int FLAG_LT = 0;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_WR_LO = 2'd1,
        WB_WR_HI = 2'd2
    } wb_state_e;

endpackage

// File: rtl/alu_writeback_seq_status_flag_reg.sv
// Status-flag register: W bits, synchronous active-high reset, load enable.
// Ports: clk, rst, load (capture d), d (next flags), q (registered flags).
module status_flag_reg
    import alu_writeback_seq_pkg::*;
#(
    parameter int W = FLAG_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] flags_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else if (load) begin
            flags_q <= d;
        end
    end

    assign q = flags_q;

endmodule

// File: rtl/alu_writeback_seq.sv
// Writeback sequencer: splits a 2*DATA_W execute result into one or two
// register-file writes and holds the status flags.
// Ports: in_* (execute handshake + payload), rf_* (write port),
// flags (status register), busy (write in progress).
module alu_writeback_seq
    import alu_writeback_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*DATA_W-1:0] in_result,
    input  logic                in_wen,
    input  logic                in_wide,
    input  logic [REG_AW-1:0]   in_rd,
    input  logic                in_flag_we,
    input  logic [FLAG_W-1:0]   in_flags,
    output logic                rf_we,
    output logic [REG_AW-1:0]   rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic [FLAG_W-1:0]   flags,
    output logic                busy
);

    wb_state_e           state_q, state_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic                wide_q, wide_d;
    logic                we_q, we_d;
    logic [REG_AW-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                accept;

    // Only the second beat of a wide write blocks the upstream stage.
    assign in_ready = !rst && !(state_q == WB_WR_LO && wide_q);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = WB_IDLE;
        hi_d    = hi_q;
        rd_d    = rd_q;
        wide_d  = wide_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (state_q == WB_WR_LO && wide_q) begin
            state_d = WB_WR_HI;
            we_d    = 1'b1;
            waddr_d = rd_q + 1'b1;
            wdata_d = hi_q;
        end else if (accept) begin
            // Low write is issued from the inputs so it lands in N+1.
            state_d = WB_WR_LO;
            hi_d    = in_result[2*DATA_W-1:DATA_W];
            rd_d    = in_rd;
            wide_d  = in_wide && in_wen;
            we_d    = in_wen;
            waddr_d = in_rd;
            wdata_d = in_result[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WB_IDLE;
            hi_q    <= '0;
            rd_q    <= '0;
            wide_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            rd_q    <= rd_d;
            wide_q  <= wide_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    status_flag_reg #(
        .W (FLAG_W)
    ) u_flags (
        .clk  (clk),
        .rst  (rst),
        .load (accept && in_flag_we),
        .d    (in_flags),
        .q    (flags)
    );

    assign rf_we    = we_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;
    assign busy     = (state_q != WB_IDLE);

endmodule

// File: tb/tb_alu_writeback_seq.sv
// Directed bench for alu_writeback_seq with hand-computed expectations.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_alu_writeback_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_wen;
    logic        in_wide;
    logic [3:0]  in_rd;
    logic        in_flag_we;
    logic [4:0]  in_flags;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [4:0]  flags;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_writeback_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_wen     (in_wen),
        .in_wide    (in_wide),
        .in_rd      (in_rd),
        .in_flag_we (in_flag_we),
        .in_flags   (in_flags),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .flags      (flags),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res,
                         input logic wen, input logic wide,
                         input logic [3:0] rd, input logic fwe,
                         input logic [4:0] fl);
        in_valid   = v;
        in_result  = res;
        in_wen     = wen;
        in_wide    = wide;
        in_rd      = rd;
        in_flag_we = fwe;
        in_flags   = fl;
        #0;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 32'h0, 0, 0, 4'd0, 0, 5'd0);
        #1;
        check("rst_ready", in_ready, 0);
        step();
        step();
        check("rst_we", rf_we, 0);
        check("rst_flags", flags, 0);
        check("rst_busy", busy, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_ready2", in_ready, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", in_ready, 1);

        // Narrow back-to-back stream
        drive(1, 32'h0000_AAAA, 1, 0, 4'd1, 0, 5'd0);
        step();
        check("n1_we", rf_we, 1);
        check("n1_addr", rf_waddr, 1);
        check("n1_data", rf_wdata, 16'hAAAA);
        check("n1_ready", in_ready, 1);
        drive(1, 32'h0000_5555, 1, 0, 4'd2, 0, 5'd0);
        step();
        check("n2_we", rf_we, 1);
        check("n2_addr", rf_waddr, 2);
        check("n2_data", rf_wdata, 16'h5555);
        check("n2_ready", in_ready, 1);
        drive(1, 32'h0000_00FF, 1, 0, 4'd3, 0, 5'd0);
        step();
        check("n3_we", rf_we, 1);
        check("n3_addr", rf_waddr, 3);
        check("n3_data", rf_wdata, 16'h00FF);
        drive(0, 32'h0, 0, 0, 4'd0, 0, 5'd0);
        step();
        check("n_idle_we", rf_we, 0);
        check("n_idle_busy", busy, 0);
        check("n_idle_hold", rf_waddr, 3);

        // Wide write with rd wrap, next transaction held valid
        drive(1, 32'h1234_ABCD, 1, 1, 4'd15, 0, 5'd0);
        step();
        check("w_lo_we", rf_we, 1);
        check("w_lo_addr", rf_waddr, 15);
        check("w_lo_data", rf_wdata, 16'hABCD);
        drive(1, 32'h0000_BEEF, 1, 0, 4'd5, 0, 5'd0);
        check("w_lo_ready", in_ready, 0);
        step();
        check("w_hi_we", rf_we, 1);
        check("w_hi_addr", rf_waddr, 0);
        check("w_hi_data", rf_wdata, 16'h1234);
        check("w_hi_ready", in_ready, 1);
        step();
        check("w_nx_we", rf_we, 1);
        check("w_nx_addr", rf_waddr, 5);
        check("w_nx_data", rf_wdata, 16'hBEEF);
        drive(0, 32'h0, 0, 0, 4'd0, 0, 5'd0);
        step();
        check("w_idle_we", rf_we, 0);

        // Wide with no follow-on: high half still completes
        drive(1, 32'hCAFE_0001, 1, 1, 4'd8, 0, 5'd0);
        step();
        drive(0, 32'h0, 0, 0, 4'd0, 0, 5'd0);
        step();
        check("w2_hi_we", rf_we, 1);
        check("w2_hi_addr", rf_waddr, 9);
        check("w2_hi_data", rf_wdata, 16'hCAFE);
        step();
        check("w2_idle_we", rf_we, 0);
        check("w2_idle_busy", busy, 0);

        // Flags only
        drive(1, 32'h0, 0, 0, 4'd7, 1, 5'b00110);
        step();
        check("f1_we", rf_we, 0);
        check("f1_flags", flags, 5'b00110);
        check("f1_busy", busy, 1);
        drive(1, 32'h0, 0, 0, 4'd7, 0, 5'b11111);
        step();
        check("f2_flags", flags, 5'b00110);
        check("f2_we", rf_we, 0);
        drive(0, 32'h0, 0, 0, 4'd0, 0, 5'd0);
        step();

        // wen=0 with wide=1 behaves as narrow
        drive(1, 32'hFFFF_FFFF, 0, 1, 4'd9, 0, 5'd0);
        step();
        check("nw_we", rf_we, 0);
        check("nw_busy", busy, 1);
        check("nw_ready", in_ready, 1);
        drive(0, 32'h0, 0, 0, 4'd0, 0, 5'd0);
        step();
        check("nw_we2", rf_we, 0);
        check("nw_busy2", busy, 0);

        // Reset during a wide write
        drive(1, 32'h5678_9ABC, 1, 1, 4'd4, 0, 5'd0);
        step();
        check("rw_lo_we", rf_we, 1);
        check("rw_lo_addr", rf_waddr, 4);
        check("rw_flags_pre", flags, 5'b00110);
        drive(0, 32'h0, 0, 0, 4'd0, 0, 5'd0);
        rst = 1'b1;
        #0;
        check("rw_ready", in_ready, 0);
        step();
        check("rw_we", rf_we, 0);
        check("rw_flags", flags, 0);
        check("rw_busy", busy, 0);
        rst = 1'b0;
        step();
        check("rw_after_we", rf_we, 0);
        check("rw_after_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_writeback_seq.md
Name: alu_writeback_seq

Overview:
- Stage directly downstream of the logic unit in the 16-bit RISC datapath.
- Accepts one execute result per handshake: a 32-bit result plus the five compare/zero flags {za,zb,eq,gt,lt}.
- Sequences the result into the 16-bit register-file write port. Narrow results take one write; wide results take two consecutive writes (low half to rd, high half to rd+1).
- Holds the architectural status-flag register used by branch logic.

Parameters:
- DATA_W, 16, register-file data width; the result is 2*DATA_W bits.
- REG_AW, 4, register-file address width (16 registers).
- FLAG_W, 5, status flags, packed {za,zb,eq,gt,lt} with za at the MSB.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  execute stage presents a result.
- in_ready  out  1  stage can accept this cycle.
- in_result  in  2*DATA_W  execute result; [15:0] is the low half, [31:16] the high half.
- in_wen  in  1  result is to be written to the register file.
- in_wide  in  1  write both halves; ignored when in_wen=0.
- in_rd  in  REG_AW  destination register index.
- in_flag_we  in  1  update the status-flag register.
- in_flags  in  FLAG_W  {za,zb,eq,gt,lt} from execute.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_AW  register-file write address.
- rf_wdata  out  DATA_W  register-file write data.
- flags  out  FLAG_W  registered status flags.
- busy  out  1  a write is in progress (state != IDLE).

Behaviour:
- Reset: state=IDLE; rf_we=0, rf_waddr=0, rf_wdata=0, flags=0, busy=0.
- in_ready is combinational and is forced to 0 while rst=1.
- A transaction is accepted when in_valid && in_ready. On acceptance, latch result, rd, wen and wide_eff = in_wide && in_wen.
- FSM states: IDLE, WR_LO, WR_HI.
  - IDLE: accept → WR_LO; otherwise stay.
  - WR_LO: if wide_eff → WR_HI. Otherwise, accept → WR_LO; no accept → IDLE.
  - WR_HI: accept → WR_LO; no accept → IDLE.
- in_ready = !(state==WR_LO && wide_eff). Narrow results sustain one per cycle; wide results occupy two cycles.
- Outputs are registered. For a transaction accepted in cycle N:
  - Cycle N+1 (WR_LO): rf_we=wen_q, rf_waddr=rd_q, rf_wdata=result_q[15:0].
  - Cycle N+2 (WR_HI, wide only): rf_we=1, rf_waddr=rd_q+1 mod 2^REG_AW (rd=15 wraps to 0), rf_wdata=result_q[31:16].
- With in_wen=0 the transaction still spends its WR_LO cycle, with rf_we=0. rf_waddr and rf_wdata still show the latched values; they are don't-care for checking.
- In IDLE, rf_we=0 and rf_waddr/rf_wdata hold their last values.
- Flags: if in_flag_we on acceptance, flags take in_flags in cycle N+1, the same edge that starts WR_LO. Otherwise flags hold their value.
- Flags are updated independently of wen and wide.
- Simultaneous events: in WR_HI, a new acceptance latches the new transaction while the high-half write drives the outputs. The new low write follows in the next cycle, with no bubble.
- If in_valid is low, nothing is latched; the high half still completes.
- Reset mid-operation: a pending WR_LO or WR_HI write is dropped (no rf_we after the reset edge), and flags are cleared.
- in_result is never modified: no sign extension, no width change.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, WR_LO=2'd1, WR_HI=2'd2), flag bit indices (FLAG_ZA=4, FLAG_ZB=3, FLAG_EQ=2, FLAG_GT=1, FLAG_LT=0), and DATA_W, REG_AW, FLAG_W defaults. The logic unit and branch unit use the same package.
- Natural sub-module: status_flag_reg, a FLAG_W-wide register with synchronous reset and load enable, instantiated once for flags.

Test Plan:
- Reset then idle: rst high 2 cycles → rf_we=0, flags=5'b0, in_ready=0 during reset and 1 after.
- Narrow stream: 3 back-to-back accepts, rd=1,2,3, results 0x0000_AAAA, 0x0000_5555, 0x0000_00FF, wen=1, wide=0 → rf_we high 3 consecutive cycles starting N+1, addresses 1,2,3, data AAAA, 5555, 00FF; in_ready stays 1.
- Wide with wrap: rd=15, result 0x1234_ABCD, wide=1 → N+1: addr 15 data ABCD; N+2: addr 0 data 1234; in_ready=0 during N+1; a new transaction held valid is accepted at N+2 and written at N+3.
- Flags only: wen=0, flag_we=1, in_flags=5'b00110 (eq=1, gt=1) → no rf_we; flags=5'b00110 from N+1. A following transaction with flag_we=0 and in_flags=5'b11111 leaves flags at 5'b00110.
- wen=0 with wide=1: treated as narrow → no rf_we, busy 1 cycle, in_ready stays 1.
- Reset mid-wide: accept wide rd=4 at N, assert rst in N+1 → no rf_we at N+2, flags=0, state IDLE.
